// File: rtl/ltmr_pkg.sv
// Shared definitions for the LTMR register family: majority vote helper and default sizes.
package ltmr_pkg;

    localparam int unsigned LTMR_WIDTH = 8;
    localparam int unsigned LTMR_CNT_W = 8;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (b & c) | (a & c);
    endfunction

endpackage

// File: rtl/ltmr_reset_deglitch.sv
// Reset glitch filter: CDN ORed with a delayed copy of itself, so assertion is delayed
// and release is immediate. The delay element is a CP-sampled flop standing in for DEL3.
module ltmr_reset_deglitch (
    input  logic i_clk,
    input  logic i_cdn,
    output logic o_rst_n
);

    (* dont_touch = "true" *) logic r_cdn_del;

    // Deliberately unreset: it must not follow CDN low without the delay.
    always_ff @(posedge i_clk) begin
        r_cdn_del <= i_cdn;
    end

    assign o_rst_n = i_cdn | r_cdn_del;

endmodule

// File: rtl/ltmr_scrub_reg_bank.sv
// Triple-modular-redundant register bank with majority vote, per-cycle scrubbing,
// SEU pulse flag and saturating upset counter.
module ltmr_scrub_reg_bank
    import ltmr_pkg::*;
#(
    parameter int unsigned      WIDTH     = LTMR_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int unsigned      CNT_W     = LTMR_CNT_W
) (
    input  logic             CP,
    input  logic             CDN,
    input  logic [WIDTH-1:0] D,
    input  logic             EN,
    input  logic             CNT_CLR,
    output logic [WIDTH-1:0] Q,
    output logic             SEU_FLAG,
    output logic [CNT_W-1:0] SEU_CNT
);

    logic                                 w_rst_n;
    (* dont_touch = "true" *) logic [WIDTH-1:0] copy_a;
    (* dont_touch = "true" *) logic [WIDTH-1:0] copy_b;
    (* dont_touch = "true" *) logic [WIDTH-1:0] copy_c;
    logic [WIDTH-1:0]                     w_vote;
    logic [WIDTH-1:0]                     w_next;
    logic                                 w_mismatch;
    logic                                 r_seu_flag;
    logic [CNT_W-1:0]                     r_seu_cnt;

    ltmr_reset_deglitch u_rst_dg (
        .i_clk   (CP),
        .i_cdn   (CDN),
        .o_rst_n (w_rst_n)
    );

    for (genvar g = 0; g < WIDTH; g++) begin : g_vote
        assign w_vote[g] = maj3(copy_a[g], copy_b[g], copy_c[g]);
    end

    assign w_mismatch = |((copy_a ^ copy_b) | (copy_b ^ copy_c));
    assign w_next     = EN ? D : w_vote;

    // Separate processes per copy keep the three registers distinct.
    always_ff @(posedge CP or negedge w_rst_n) begin
        if (!w_rst_n) copy_a <= RESET_VAL;
        else          copy_a <= w_next;
    end

    always_ff @(posedge CP or negedge w_rst_n) begin
        if (!w_rst_n) copy_b <= RESET_VAL;
        else          copy_b <= w_next;
    end

    always_ff @(posedge CP or negedge w_rst_n) begin
        if (!w_rst_n) copy_c <= RESET_VAL;
        else          copy_c <= w_next;
    end

    always_ff @(posedge CP or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_seu_flag <= 1'b0;
            r_seu_cnt  <= '0;
        end else begin
            r_seu_flag <= w_mismatch;
            if (CNT_CLR) begin
                r_seu_cnt <= '0;
            end else if (w_mismatch && (r_seu_cnt != '1)) begin
                r_seu_cnt <= r_seu_cnt + CNT_W'(1);
            end
        end
    end

    assign Q        = w_vote;
    assign SEU_FLAG = r_seu_flag;
    assign SEU_CNT  = r_seu_cnt;

endmodule

// File: tb/tb_ltmr_scrub_reg_bank.sv
// Randomised scoreboard bench: an 8-bit and a 2-bit counter instance share all stimulus.
module tb_ltmr_scrub_reg_bank;

    logic       CP = 1'b0;
    logic       CDN;
    logic [7:0] D;
    logic       EN;
    logic       CNT_CLR;
    logic [7:0] q8, q2;
    logic       f8, f2;
    logic [7:0] c8;
    logic [1:0] c2;

    always #5 CP = ~CP;

    ltmr_scrub_reg_bank #(.WIDTH(8), .RESET_VAL(8'hA5), .CNT_W(8)) dut8 (
        .CP(CP), .CDN(CDN), .D(D), .EN(EN), .CNT_CLR(CNT_CLR),
        .Q(q8), .SEU_FLAG(f8), .SEU_CNT(c8)
    );

    ltmr_scrub_reg_bank #(.WIDTH(8), .RESET_VAL(8'hA5), .CNT_W(2)) dut2 (
        .CP(CP), .CDN(CDN), .D(D), .EN(EN), .CNT_CLR(CNT_CLR),
        .Q(q2), .SEU_FLAG(f2), .SEU_CNT(c2)
    );

    typedef struct {
        logic [7:0] q;
        logic       flag;
        int         cnt8;
        int         cnt2;
    } exp_t;

    exp_t       sbq[$];
    int         total = 0;
    int         bad   = 0;
    logic [7:0] ma, mb, mc;
    int         m8, m2;
    logic [7:0] inj_a, inj_b, inj_c;

    function automatic logic [7:0] vote(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[i] = ((int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2);
        end
        return r;
    endfunction

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // mode 0 = normal, 1 = CDN held low across the edge, 2 = short CDN glitch
    task automatic step(input int mode, input logic en, input logic [7:0] d, input logic clr,
                        input logic [7:0] xa, input logic [7:0] xb, input logic [7:0] xc);
        exp_t       e;
        logic [7:0] v;
        bit         mism;
        @(negedge CP);
        EN      = en;
        D       = d;
        CNT_CLR = clr;
        CDN     = (mode == 1) ? 1'b0 : 1'b1;
        if (mode != 1 && (xa | xb | xc) != 8'h00) begin
            ma ^= xa;
            mb ^= xb;
            mc ^= xc;
            inj_a = ma;
            inj_b = mb;
            inj_c = mc;
            force dut8.copy_a = inj_a;
            force dut8.copy_b = inj_b;
            force dut8.copy_c = inj_c;
            force dut2.copy_a = inj_a;
            force dut2.copy_b = inj_b;
            force dut2.copy_c = inj_c;
            #1;
            release dut8.copy_a;
            release dut8.copy_b;
            release dut8.copy_c;
            release dut2.copy_a;
            release dut2.copy_b;
            release dut2.copy_c;
        end
        if (mode == 2) begin
            CDN = 1'b0;
            #2;
            CDN = 1'b1;
        end
        if (mode == 1) begin
            ma = 8'hA5;
            mb = 8'hA5;
            mc = 8'hA5;
            m8 = 0;
            m2 = 0;
            e.q    = 8'hA5;
            e.flag = 1'b0;
        end else begin
            mism = !(ma == mb && mb == mc);
            v    = en ? d : vote(ma, mb, mc);
            ma = v;
            mb = v;
            mc = v;
            if (clr) begin
                m8 = 0;
                m2 = 0;
            end else if (mism) begin
                if (m8 < 255) m8++;
                if (m2 < 3)   m2++;
            end
            e.q    = v;
            e.flag = mism;
        end
        e.cnt8 = m8;
        e.cnt2 = m2;
        sbq.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CP);
            #2;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("q8",    int'(q8), int'(e.q));
                check("flag8", int'(f8), int'(e.flag));
                check("cnt8",  int'(c8), e.cnt8);
                check("q2",    int'(q2), int'(e.q));
                check("flag2", int'(f2), int'(e.flag));
                check("cnt2",  int'(c2), e.cnt2);
            end
        end
    end

    initial begin : driver
        int         r;
        int         kind;
        logic [7:0] b0, b1;
        CDN = 1'b0; EN = 1'b0; D = 8'h00; CNT_CLR = 1'b0;
        ma = 8'hA5; mb = 8'hA5; mc = 8'hA5; m8 = 0; m2 = 0;

        repeat (3) step(1, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00);
        step(0, 1, 8'h3C, 0, 8'h00, 8'h00, 8'h00);
        repeat (10) step(0, 0, 8'hFF, 0, 8'h00, 8'h00, 8'h00);
        step(0, 0, 8'h00, 0, 8'h00, 8'h01, 8'h00);
        step(0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00);
        step(0, 0, 8'h00, 0, 8'h04, 8'h00, 8'h20);
        step(0, 0, 8'h00, 1, 8'h00, 8'h00, 8'h00);
        repeat (5) begin
            step(0, 0, 8'h00, 0, 8'h10, 8'h00, 8'h00);
            step(0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00);
        end
        step(0, 0, 8'h00, 1, 8'h00, 8'h02, 8'h00);
        step(0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00);
        step(2, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00);
        step(0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00);
        repeat (2) step(1, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00);
        step(0, 0, 8'h00, 0, 8'h80, 8'h80, 8'h00);
        step(0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00);

        for (int n = 0; n < 400; n++) begin
            r    = $urandom_range(0, 99);
            kind = $urandom_range(0, 4);
            b0   = 8'h01 << $urandom_range(0, 7);
            b1   = 8'h01 << $urandom_range(0, 7);
            if (r < 2) begin
                repeat (2) step(1, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00);
            end else begin
                case (kind)
                    2:       step((r < 6) ? 2 : 0, ($urandom_range(0, 3) == 0), 8'($urandom),
                                  ($urandom_range(0, 15) == 0), b0, 8'h00, 8'h00);
                    3:       step((r < 6) ? 2 : 0, ($urandom_range(0, 3) == 0), 8'($urandom),
                                  ($urandom_range(0, 15) == 0), 8'h00, b0, b1);
                    4:       step((r < 6) ? 2 : 0, ($urandom_range(0, 3) == 0), 8'($urandom),
                                  ($urandom_range(0, 15) == 0), b0, 8'h00, b0);
                    default: step((r < 6) ? 2 : 0, ($urandom_range(0, 1) == 0), 8'($urandom),
                                  ($urandom_range(0, 15) == 0), 8'h00, 8'h00, 8'h00);
                endcase
            end
        end

        repeat (3) @(negedge CP);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
